serial_frame_tx: RTL and testbench

- Moore-style serial transmitter that generates the framed bit stream consumed by our serial "101" pattern detector.
- Accepts a parallel word over a valid/ready handshake.
- Emits preamble 1,0,1, then the payload MSB first, then an optional parity bit, then a zero gap, on a single registered serial line.
- Sits between the parallel-side producer and the single-wire link to the detector.

---
 rtl/serial_frame_tx_if.sv | 22 ++
 rtl/serial_frame_tx.sv | 151 +++++++++++++++
 tb/tb_serial_frame_tx.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_tx_if.sv
// Parallel handshake and serial-line signals for serial_frame_tx.
// master = producer/observer side, slave = the transmitter.
interface serial_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              x_out;
  logic              tx_busy;
  logic              frame_done;

  modport master (
    output din, din_valid,
    input  din_ready, x_out, tx_busy, frame_done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, x_out, tx_busy, frame_done
  );
endinterface

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: preamble 1,0,1, payload MSB first, optional even
// parity bit (SERIAL_FRAME_TX_PARITY_EN), then GAP_CYCLES zero cycles.
module serial_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input logic              clk,
  input logic              rst,
  serial_frame_tx_if.slave bus
);

  // Counter also has to hold the preamble and gap reloads, so it is widened
  // beyond $clog2(DATA_W)+1 when DATA_W or GAP_CYCLES would not fit.
  localparam int CW_DATA = $clog2(DATA_W) + 1;
  localparam int CW_GAP  = $clog2(GAP_CYCLES + 1) + 1;
  localparam int CW_A    = (CW_DATA > CW_GAP) ? CW_DATA : CW_GAP;
  localparam int CW      = (CW_A > 2) ? CW_A : 2;

  localparam logic [CW-1:0] PRE_LD  = CW'(2);
  localparam logic [CW-1:0] DATA_LD = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
`ifdef SERIAL_FRAME_TX_PARITY_EN
    S_PAR,
`endif
    S_GAP
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              x_q, x_d;
  logic              done_q, done_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      x_q     <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      x_q     <= x_d;
      done_q  <= done_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // x_d/done_d describe the cycle being entered, keeping the line registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    x_d     = 1'b0;
    done_d  = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.din_valid) begin
          state_d = S_PRE;
          cnt_d   = PRE_LD;
          shift_d = bus.din;
          x_d     = 1'b1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
          par_d   = ^bus.din;
`endif
        end
      end
      S_PRE: begin
        if (cnt_q == '0) begin
          state_d = S_DATA;
          cnt_d   = DATA_LD;
          x_d     = shift_q[DATA_W-1];
          shift_d = shift_q << 1;
          done_d  = !PAR_EN && (DATA_W == 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
          x_d   = ~cnt_d[0];
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
          state_d = S_PAR;
          x_d     = par_q;
          done_d  = 1'b1;
`else
          if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
            cnt_d   = GAP_LD;
          end else begin
            state_d = S_IDLE;
          end
`endif
        end else begin
          cnt_d   = cnt_q - CW'(1);
          x_d     = shift_q[DATA_W-1];
          shift_d = shift_q << 1;
          done_d  = !PAR_EN && (cnt_d == '0);
        end
      end
`ifdef SERIAL_FRAME_TX_PARITY_EN
      S_PAR: begin
        if (GAP_CYCLES > 0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LD;
        end else begin
          state_d = S_IDLE;
        end
      end
`endif
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.din_ready  = (state_q == S_IDLE) && !rst;
  assign bus.tx_busy    = (state_q != S_IDLE);
  assign bus.x_out      = x_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: an 8-bit/gap-2 instance and a
// 1-bit/gap-0 instance; expected per-cycle line state is queued at accept time.
module tb_serial_frame_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  serial_frame_tx_if #(.DATA_W(8)) b0 ();
  serial_frame_tx_if #(.DATA_W(1)) b1 ();

  serial_frame_tx #(.DATA_W(8), .GAP_CYCLES(2)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  serial_frame_tx #(.DATA_W(1), .GAP_CYCLES(0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  // Entry layout: {x_out, frame_done, tx_busy, din_ready}
  logic [3:0] q0[$];
  logic [3:0] q1[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, n_cyc);
    end
  endtask

  function automatic logic [3:0] obs0();
    return {b0.x_out, b0.frame_done, b0.tx_busy, b0.din_ready};
  endfunction

  function automatic logic [3:0] obs1();
    return {b1.x_out, b1.frame_done, b1.tx_busy, b1.din_ready};
  endfunction

  function automatic void push(input int which, input logic [3:0] e);
    if (which == 0) q0.push_back(e);
    else            q1.push_back(e);
  endfunction

  // Expected line activity from the accept edge up to and including the
  // first IDLE cycle after the frame.
  function automatic void push_frame(input int which, input logic [7:0] data,
                                     input int w, input int gap);
    logic bits[$];
    logic par;
    par = 1'b0;
    bits.push_back(1'b1);
    bits.push_back(1'b0);
    bits.push_back(1'b1);
    for (int i = w - 1; i >= 0; i--) begin
      bits.push_back(data[i]);
      par ^= data[i];
    end
`ifdef SERIAL_FRAME_TX_PARITY_EN
    bits.push_back(par);
`endif
    for (int i = 0; i < bits.size(); i++)
      push(which, {bits[i], (i == bits.size() - 1), 1'b1, 1'b0});
    for (int i = 0; i < gap; i++)
      push(which, 4'b0010);
    push(which, 4'b0001);
  endfunction

  task automatic tick();
    logic [3:0] e;
    @(posedge clk);
    #1;
    n_cyc++;
    if (n_cyc > 20000) begin
      $display("FAIL timeout: got=%0d cycles expected<=20000", n_cyc);
      $fatal(1);
    end
    if (q0.size() != 0) begin
      e = q0.pop_front();
      check("dut0_line", 32'(obs0()), 32'(e));
    end
    if (q1.size() != 0) begin
      e = q1.pop_front();
      check("dut1_line", 32'(obs1()), 32'(e));
    end
  endtask

  task automatic drain();
    while (q0.size() != 0 || q1.size() != 0) tick();
  endtask

  // Present a word and hold valid until the model says the DUT accepts it.
  task automatic send0(input logic [7:0] word, input bit hold);
    b0.din       = word;
    b0.din_valid = 1'b1;
    while (q0.size() != 0) tick();
    push_frame(0, word, 8, 2);
    tick();
    if (!hold) b0.din_valid = 1'b0;
  endtask

  initial begin
    b0.din = '0;
    b0.din_valid = 1'b0;
    b1.din = '0;
    b1.din_valid = 1'b0;

    tick();
    check("rst_d0", 32'(obs0()), 32'h0);
    check("rst_d1", 32'(obs1()), 32'h0);
    rst = 1'b0;
    #1;
    check("idle_d0", 32'(obs0()), 32'h1);
    check("idle_d1", 32'(obs1()), 32'h1);
    push(0, 4'b0001);
    push(1, 4'b0001);
    tick();

    // Basic frame and a second pattern
    send0(8'hA5, 1'b0);
    drain();
    send0(8'h07, 1'b0);
    drain();

    // Back-to-back with valid held, then no third accept
    send0(8'hFF, 1'b1);
    send0(8'h00, 1'b0);
    drain();
    repeat (3) push(0, 4'b0001);
    drain();

    // Busy ignore: scramble valid/din for the whole frame
    send0(8'h3C, 1'b0);
    while (q0.size() > 1) begin
      b0.din_valid = 1'($urandom_range(0, 1));
      b0.din       = 8'($urandom);
      tick();
    end
    b0.din_valid = 1'b0;
    tick();

    // Reset during the 4th data bit
    send0(8'h5A, 1'b0);
    repeat (6) tick();
    rst = 1'b1;
    #1;
    check("rst_mid", 32'(obs0()), 32'h0);
    q0.delete();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_rel", 32'(obs0()), 32'h1);
    repeat (2) push(0, 4'b0001);
    drain();
    send0(8'hC3, 1'b0);
    drain();

    // DATA_W=1, GAP_CYCLES=0
    b1.din       = 1'b1;
    b1.din_valid = 1'b1;
    push_frame(1, 8'h01, 1, 0);
    tick();
    b1.din_valid = 1'b0;
    drain();
    repeat (2) push(1, 4'b0001);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
